ebi_slave_frontend: RTL and testbench
=====================================

Name: ebi_slave_frontend

Overview:
Host-side front end for the ARM external-bus (EBI) link on the GPIO header. It synchronises the asynchronous active-low CE/OE/WE strobes and the 16-bit data bus into the `clock` domain. Each host bus cycle becomes a clean internal transaction: a one-cycle write strobe with captured data, or a read request/acknowledge handshake. It also drives the tristate enable for read-back. It sits directly upstream of the shift-register and data-path logic that consumes host writes and supplies read data.

Parameters:
- DATA_W, 16: bus data width.
- SYNC_STAGES, 2: flip-flop stages on each strobe and data synchroniser; legal range 2..4.
- TIMEOUT, 15: cycles to wait for rd_ack before the error word is substituted; legal range 1..255.
- ERR_WORD, 16'hDEAD: word driven on the bus when a read times out.

Ports:
- clock, input, 1: system clock (PLL c0).
- reset_n, input, 1: asynchronous active-low reset.
- ce_n, input, 1: host chip enable, active low, asynchronous.
- oe_n, input, 1: host output enable, active low, asynchronous.
- we_n, input, 1: host write enable, active low, asynchronous.
- bus_din, input, DATA_W: pad data in, asynchronous.
- bus_dout, output, DATA_W: pad data out.
- bus_oe, output, 1: pad tristate enable; 1 = FPGA drives the bus.
- wr_valid, output, 1: one-cycle write strobe.
- wr_data, output, DATA_W: captured write word; valid while wr_valid = 1, held otherwise.
- rd_req, output, 1: one-cycle read request to the downstream logic.
- rd_ack, input, 1: downstream read acknowledge.
- rd_data, input, DATA_W: read word; sampled when rd_ack = 1.
- busy, output, 1: state != IDLE.
- err, output, 1: one-cycle protocol or timeout error pulse.

Behaviour:
- Reset (asynchronous, reset_n = 0): all synchroniser stages load 1 for strobes and 0 for data; state = IDLE; bus_oe = 0; bus_dout = 0; wr_valid = 0; wr_data = 0; rd_req = 0; busy = 0; err = 0; timeout counter = 0.
- Synchronisers: ce_s, oe_s, we_s and din_s are the SYNC_STAGES-delayed versions of the inputs. All decisions use synchronised values only. All outputs are registered.
- IDLE:
  - ce_s = 0 and we_s = 0 -> WRITE. Priority over OE.
  - ce_s = 0 and we_s = 0 and oe_s = 0 together -> WRITE, plus err pulse.
  - ce_s = 0 and oe_s = 0 -> READ, with rd_req = 1 for exactly the first READ cycle.
- WRITE:
  - Every cycle, a data-hold register loads din_s.
  - On we_s 0->1 with ce_s = 0: wr_valid = 1 for one cycle, wr_data = the hold value from the previous cycle (last sample taken while WE was low); next state IDLE.
  - On ce_s 0->1 before we_s rises: abort, no wr_valid, err pulse, next state IDLE.
- READ:
  - Timeout counter starts at 0 and increments each cycle.
  - rd_ack = 1 before the counter reaches TIMEOUT: bus_dout <= rd_data and bus_oe <= 1 on the next edge; next state HOLD.
  - Counter reaches TIMEOUT without rd_ack: bus_dout <= ERR_WORD, bus_oe <= 1, err pulse; next state HOLD.
  - oe_s or ce_s returns to 1 while still in READ: bus_oe stays 0, no err; next state IDLE. A late rd_ack in IDLE is ignored.
- HOLD:
  - bus_dout and bus_oe are held.
  - oe_s = 1 or ce_s = 1 -> bus_oe <= 0 on the next edge, next state IDLE.
  - WE assertion in HOLD is ignored; bus_oe never coincides with a WRITE state.
- Back-to-back host cycles: IDLE is re-entered for at least one cycle between transactions.
- Turnaround: worst-case latency from the host releasing OE to bus_oe = 0 is SYNC_STAGES + 1 clocks.
- Reset mid-transaction: immediate return to reset values; bus_oe drops asynchronously; no strobe is emitted.

Optional Feature:
- EBI_TXN_COUNT_EN defined:
  - Adds outputs wr_count[15:0], rd_count[15:0] and err_count[7:0], all reset to 0.
  - wr_count increments on wr_valid; rd_count increments on entry to HOLD; err_count increments on err.
  - All counters wrap modulo 2^width.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Write: CE low, WE low for 6 cycles with bus_din = 16'h1234, WE high -> exactly one wr_valid, wr_data = 16'h1234, at SYNC_STAGES + 1 cycles after the WE rise; err = 0.
2. Read with ack: CE and OE low; rd_ack asserted 3 cycles after rd_req with rd_data = 16'hBEEF -> bus_oe = 1 with bus_dout = 16'hBEEF; OE high -> bus_oe = 0 within 3 cycles; busy returns 0.
3. Read timeout: CE and OE low, rd_ack never asserted -> err pulse once and bus_dout = 16'hDEAD after TIMEOUT = 15 cycles.
4. Abort: CE low, WE low, then CE high with WE still low -> no wr_valid, one err pulse, state IDLE.
5. Conflict: WE and OE low simultaneously -> WRITE path taken, err pulse, rd_req never asserted, bus_oe stays 0.
6. Reset during HOLD with bus_oe = 1 -> bus_oe = 0 immediately (asynchronous); after release, a write of 16'h00FF completes normally; with EBI_TXN_COUNT_EN, wr_count = 1 after the write.

Source files
------------

// File: rtl/ebi_slave_frontend.sv
// EBI host-bus front end: synchronises CE/OE/WE/data, emits write strobes and read handshakes, drives readback tristate.
// Latency SYNC_STAGES+1 clocks from pad to strobe; no backpressure, rd_ack is awaited up to TIMEOUT cycles. Option: EBI_TXN_COUNT_EN.
module ebi_slave_frontend #(
    parameter int                DATA_W      = 16,
    parameter int                SYNC_STAGES = 2,
    parameter int                TIMEOUT     = 15,
    parameter logic [DATA_W-1:0] ERR_WORD    = 16'hDEAD
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ce_n,
    input  logic              oe_n,
    input  logic              we_n,
    input  logic [DATA_W-1:0] bus_din,
    output logic [DATA_W-1:0] bus_dout,
    output logic              bus_oe,
    output logic              wr_valid,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_req,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
`ifdef EBI_TXN_COUNT_EN
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count,
    output logic [7:0]        err_count,
`endif
    output logic              err
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, HOLD} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] ce_sync, oe_sync, we_sync;
    logic [DATA_W-1:0]      din_sync [SYNC_STAGES];
    logic                   ce_s, oe_s, we_s;
    logic [DATA_W-1:0]      din_s;

    logic [7:0]        cnt, cnt_nxt;
    logic [DATA_W-1:0] hold_q, hold_nxt;
    logic [DATA_W-1:0] dout_nxt;
    logic              oe_nxt;
    logic              wr_fire, err_fire, rd_start;

    assign ce_s  = ce_sync[SYNC_STAGES-1];
    assign oe_s  = oe_sync[SYNC_STAGES-1];
    assign we_s  = we_sync[SYNC_STAGES-1];
    assign din_s = din_sync[SYNC_STAGES-1];
    assign busy  = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ce_sync <= '1;
            oe_sync <= '1;
            we_sync <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) din_sync[i] <= '0;
        end else begin
            ce_sync     <= {ce_sync[SYNC_STAGES-2:0], ce_n};
            oe_sync     <= {oe_sync[SYNC_STAGES-2:0], oe_n};
            we_sync     <= {we_sync[SYNC_STAGES-2:0], we_n};
            din_sync[0] <= bus_din;
            for (int i = 1; i < SYNC_STAGES; i++) din_sync[i] <= din_sync[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold_nxt  = hold_q;
        dout_nxt  = bus_dout;
        oe_nxt    = bus_oe;
        wr_fire   = 1'b0;
        err_fire  = 1'b0;
        rd_start  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                // WE wins over OE; a simultaneous OE is flagged but still written
                if (!ce_s && !we_s) begin
                    state_nxt = WRITE;
                    err_fire  = !oe_s;
                end else if (!ce_s && !oe_s) begin
                    state_nxt = READ;
                    rd_start  = 1'b1;
                end
            end
            WRITE: begin
                hold_nxt = din_s;
                if (ce_s) begin
                    state_nxt = IDLE;
                    err_fire  = 1'b1;
                end else if (we_s) begin
                    state_nxt = IDLE;
                    wr_fire   = 1'b1;
                end
            end
            READ: begin
                cnt_nxt = cnt + 8'd1;
                if (ce_s || oe_s) begin
                    state_nxt = IDLE;
                end else if (cnt == 8'(TIMEOUT)) begin
                    state_nxt = HOLD;
                    dout_nxt  = ERR_WORD;
                    oe_nxt    = 1'b1;
                    err_fire  = 1'b1;
                end else if (rd_ack) begin
                    state_nxt = HOLD;
                    dout_nxt  = rd_data;
                    oe_nxt    = 1'b1;
                end
            end
            HOLD: begin
                if (ce_s || oe_s) begin
                    state_nxt = IDLE;
                    oe_nxt    = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            hold_q   <= '0;
            bus_dout <= '0;
            bus_oe   <= 1'b0;
            wr_valid <= 1'b0;
            wr_data  <= '0;
            rd_req   <= 1'b0;
            err      <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            hold_q   <= hold_nxt;
            bus_dout <= dout_nxt;
            bus_oe   <= oe_nxt;
            wr_valid <= wr_fire;
            rd_req   <= rd_start;
            err      <= err_fire;
            // hold_q still holds the last sample taken while WE was low
            if (wr_fire) wr_data <= hold_q;
        end
    end

`ifdef EBI_TXN_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_count  <= '0;
            rd_count  <= '0;
            err_count <= '0;
        end else begin
            if (wr_fire)                            wr_count  <= wr_count + 16'd1;
            if (state == READ && state_nxt == HOLD) rd_count  <= rd_count + 16'd1;
            if (err_fire)                           err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ebi_slave_frontend.sv
// Directed transaction table plus hand sequences for read abort and reset-in-HOLD.
module tb_ebi_slave_frontend;

    localparam int OP_WR = 0, OP_RD = 1, OP_ABORT = 2, OP_CONFLICT = 3;

    typedef struct {
        int          op;
        logic [15:0] data;
        int          ack_dly;
        int          exp_lat;
        int          exp_trn;
        int          exp_wr;
        int          exp_err;
        int          exp_rq;
        int          exp_oe;
        int          exp_val;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ce_n, oe_n, we_n, rd_ack;
    logic [15:0] bus_din, rd_data;
    logic [15:0] bus_dout, wr_data;
    logic        bus_oe, wr_valid, rd_req, busy, err;
`ifdef EBI_TXN_COUNT_EN
    logic [15:0] wr_count, rd_count;
    logic [7:0]  err_count;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int n_wr, n_err, n_rq, oe_seen;
    logic [15:0] last_wr;

    vec_t vecs [7];

    ebi_slave_frontend dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ce_n     (ce_n),
        .oe_n     (oe_n),
        .we_n     (we_n),
        .bus_din  (bus_din),
        .bus_dout (bus_dout),
        .bus_oe   (bus_oe),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .busy     (busy),
`ifdef EBI_TXN_COUNT_EN
        .wr_count (wr_count),
        .rd_count (rd_count),
        .err_count(err_count),
`endif
        .err      (err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (wr_valid) begin
            n_wr++;
            last_wr = wr_data;
        end
        if (err)    n_err++;
        if (rd_req) n_rq++;
        if (bus_oe) oe_seen = 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_mon;
        n_wr = 0; n_err = 0; n_rq = 0; oe_seen = 0; last_wr = 16'hxxxx;
    endtask

    task automatic run_vec(input vec_t v, output int lat, output int trn, output int val);
        bit got;
        lat = -1; trn = -1; val = -1;
        case (v.op)
            OP_WR, OP_CONFLICT: begin
                ce_n = 0; we_n = 0; bus_din = v.data;
                if (v.op == OP_CONFLICT) oe_n = 0;
                repeat (6) tick;
                we_n = 1; oe_n = 1; bus_din = ~v.data;
                for (int k = 1; k <= 20; k++) begin
                    tick;
                    if (wr_valid && lat < 0) lat = k;
                end
                val = int'(last_wr);
                ce_n = 1;
                repeat (6) tick;
            end
            OP_ABORT: begin
                ce_n = 0; we_n = 0; bus_din = v.data;
                repeat (4) tick;
                ce_n = 1;
                repeat (8) tick;
                we_n = 1;
                repeat (4) tick;
            end
            default: begin
                ce_n = 0; oe_n = 0;
                got = 0;
                for (int k = 0; k < 20; k++) begin
                    tick;
                    if (rd_req) begin got = 1; break; end
                end
                if (got) begin
                    for (int k = 0; k < 40; k++) begin
                        if (k == v.ack_dly) begin rd_ack = 1; rd_data = v.data; end
                        tick;
                        rd_ack = 0;
                        if (bus_oe) begin lat = k + 1; break; end
                    end
                    val = int'(bus_dout);
                end
                oe_n = 1;
                for (int k = 0; k < 10; k++) begin
                    tick;
                    if (!bus_oe) begin trn = k + 1; break; end
                end
                ce_n = 1;
                repeat (5) tick;
            end
        endcase
    endtask

    initial begin
        int lat, trn, val;
        vec_t wv;
        vecs[0] = '{OP_WR,       16'h1234, -1,  3, -1, 1, 0, 0, 0, 32'h1234};
        vecs[1] = '{OP_RD,       16'hBEEF,  3,  4,  3, 0, 0, 1, 1, 32'hBEEF};
        vecs[2] = '{OP_RD,       16'h1111, -1, 16,  3, 0, 1, 1, 1, 32'hDEAD};
        vecs[3] = '{OP_ABORT,    16'h7777, -1, -1, -1, 0, 1, 0, 0, -1};
        vecs[4] = '{OP_CONFLICT, 16'hA5A5, -1,  3, -1, 1, 1, 0, 0, 32'hA5A5};
        vecs[5] = '{OP_WR,       16'h5A5A, -1,  3, -1, 1, 0, 0, 0, 32'h5A5A};
        vecs[6] = '{OP_RD,       16'h0001,  0,  1,  3, 0, 0, 1, 1, 32'h0001};

        reset_n = 0; ce_n = 1; oe_n = 1; we_n = 1;
        bus_din = 16'hFFFF; rd_ack = 0; rd_data = 16'h0;
        clr_mon();
        repeat (3) tick;
        check("reset bus_oe",   int'(bus_oe),   0);
        check("reset bus_dout", int'(bus_dout), 0);
        check("reset wr_valid", int'(wr_valid), 0);
        check("reset wr_data",  int'(wr_data),  0);
        check("reset rd_req",   int'(rd_req),   0);
        check("reset busy",     int'(busy),     0);
        check("reset err",      int'(err),      0);
        reset_n = 1;
        repeat (3) tick;

        for (int i = 0; i < 7; i++) begin
            clr_mon();
            run_vec(vecs[i], lat, trn, val);
            check($sformatf("v%0d wr_valid count", i), n_wr,    vecs[i].exp_wr);
            check($sformatf("v%0d err count", i),      n_err,   vecs[i].exp_err);
            check($sformatf("v%0d rd_req count", i),   n_rq,    vecs[i].exp_rq);
            check($sformatf("v%0d bus_oe seen", i),    oe_seen, vecs[i].exp_oe);
            check($sformatf("v%0d busy at end", i),    int'(busy), 0);
            if (vecs[i].exp_val >= 0) check($sformatf("v%0d data", i), val, vecs[i].exp_val);
            if (vecs[i].exp_lat >= 0) check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].exp_trn >= 0) check($sformatf("v%0d turnaround", i), trn, vecs[i].exp_trn);
        end

        // OE released while READ is pending; a late ack must not drive the bus
        clr_mon();
        ce_n = 0; oe_n = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (rd_req) break;
        end
        oe_n = 1;
        repeat (4) tick;
        rd_ack = 1; rd_data = 16'hCAFE;
        tick;
        rd_ack = 0;
        ce_n = 1;
        repeat (6) tick;
        check("abandoned read rd_req", n_rq, 1);
        check("abandoned read bus_oe", oe_seen, 0);
        check("abandoned read err", n_err, 0);
        check("abandoned read busy", int'(busy), 0);

        // reset while in HOLD drives bus_oe low without a clock edge
        clr_mon();
        ce_n = 0; oe_n = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (rd_req) break;
        end
        rd_ack = 1; rd_data = 16'h0F0F;
        tick;
        rd_ack = 0;
        tick;
        check("hold bus_oe before reset", int'(bus_oe), 1);
        check("hold bus_dout", int'(bus_dout), 32'h0F0F);
        reset_n = 0;
        #1;
        check("async reset bus_oe", int'(bus_oe), 0);
        check("async reset busy", int'(busy), 0);
        ce_n = 1; oe_n = 1;
        repeat (2) tick;
        reset_n = 1;
        repeat (2) tick;
        clr_mon();
        wv = '{OP_WR, 16'h00FF, -1, 3, -1, 1, 0, 0, 0, 32'h00FF};
        run_vec(wv, lat, trn, val);
        check("post-reset wr_valid count", n_wr, 1);
        check("post-reset wr_data", val, 32'h00FF);
        check("post-reset latency", lat, 3);
        check("post-reset err", n_err, 0);
`ifdef EBI_TXN_COUNT_EN
        check("wr_count", int'(wr_count), 1);
        check("rd_count", int'(rd_count), 0);
        check("err_count", int'(err_count), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
